// File: rtl/clock_btn_pkg.sv
// Shared types and constants for the alarm-clock button front end.
// Optional auto-repeat is selected with CLOCK_BTN_AUTORPT_EN (see btn_cond / clock_btn_ctrl).
package clock_btn_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_t;

  localparam int NUM_BTN      = 6;
  localparam int BTN_TIMESET  = 0;
  localparam int BTN_ALARMSET = 1;
  localparam int BTN_MINADV   = 2;
  localparam int BTN_HRSADV   = 3;
  localparam int BTN_DAYADV   = 4;
  localparam int BTN_ALARMON  = 5;

  localparam int DB_CYCLES_DEF   = 16;
  localparam int HOLD_CYCLES_DEF = 64;
  localparam int RPT_CYCLES_DEF  = 16;

  // Counter width able to hold the value n.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  localparam int DB_W_DEF  = cnt_w(DB_CYCLES_DEF);
  localparam int RPT_W_DEF = cnt_w((HOLD_CYCLES_DEF > RPT_CYCLES_DEF) ? HOLD_CYCLES_DEF : RPT_CYCLES_DEF);

endpackage

// File: rtl/clock_btn_ctrl_btn_cond.sv
// One button: 2-flop synchronizer, counting debouncer, press pulse and advance strobe.
// With CLOCK_BTN_AUTORPT_EN defined the strobe auto-repeats while held; otherwise one strobe per press.
module btn_cond
  import clock_btn_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int RPT_CYCLES  = RPT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic repeat_ok,
  output logic press,
  output logic strobe
);

  localparam int DBW = cnt_w(DB_CYCLES);

  logic           s1, s2;
  logic           db, db_q;
  logic [DBW-1:0] db_cnt;

  // db only follows s2 after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
        db_cnt <= '0;
        db     <= s2;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  assign press = db & ~db_q;

`ifdef CLOCK_BTN_AUTORPT_EN
  localparam int RW = cnt_w((HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_phase;
  logic          fire;

  // rpt_cnt==0 means idle: only a fresh press may start the timer.
  assign fire = db && repeat_ok && (rpt_cnt != '0) &&
                (rpt_cnt == (rpt_phase ? RW'(RPT_CYCLES) : RW'(HOLD_CYCLES)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe    <= 1'b0;
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else begin
      strobe <= repeat_ok & (press | fire);
      if (!db || !repeat_ok) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (press) begin
        rpt_cnt   <= RW'(1);
        rpt_phase <= 1'b0;
      end else if (fire) begin
        rpt_cnt   <= RW'(1);
        rpt_phase <= 1'b1;
      end else if (rpt_cnt != '0) begin
        rpt_cnt <= rpt_cnt + RW'(1);
      end
    end
  end
`else
  localparam int unused_rpt_cfg = HOLD_CYCLES + RPT_CYCLES;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) strobe <= 1'b0;
    else      strobe <= repeat_ok & press;
  end
`endif

endmodule

// File: rtl/clock_btn_ctrl.sv
// Button front end for the alarm clock: mode FSM, advance-strobe qualification, Alarmon toggle.
// Auto-repeat of the advance strobes is enabled by defining CLOCK_BTN_AUTORPT_EN.
module clock_btn_ctrl
  import clock_btn_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int RPT_CYCLES  = RPT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timeset_raw,
  input  logic       alarmset_raw,
  input  logic       minadv_raw,
  input  logic       hrsadv_raw,
  input  logic       dayadv_raw,
  input  logic       alarmon_raw,
  output logic       Timeset,
  output logic       Alarmset,
  output logic       Minadv,
  output logic       Hrsadv,
  output logic       Dayadv,
  output logic       Alarmon,
  output logic [1:0] mode
);

  logic [NUM_BTN-1:0] raw_vec, press, strobe, repeat_ok;
  mode_t              mode_r, mode_next;
  logic               mode_hold;

  assign raw_vec = {alarmon_raw, dayadv_raw, hrsadv_raw, minadv_raw, alarmset_raw, timeset_raw};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_cond #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .RPT_CYCLES (RPT_CYCLES)
    ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw_vec[i]),
      .repeat_ok(repeat_ok[i]),
      .press    (press[i]),
      .strobe   (strobe[i])
    );
  end

  // In each state the button that owns the current mode takes priority.
  always_comb begin
    mode_next = mode_r;
    case (mode_r)
      MODE_RUN: begin
        if (press[BTN_TIMESET])       mode_next = MODE_SET_TIME;
        else if (press[BTN_ALARMSET]) mode_next = MODE_SET_ALARM;
      end
      MODE_SET_TIME: begin
        if (press[BTN_TIMESET])       mode_next = MODE_RUN;
        else if (press[BTN_ALARMSET]) mode_next = MODE_SET_ALARM;
      end
      MODE_SET_ALARM: begin
        if (press[BTN_ALARMSET])      mode_next = MODE_RUN;
        else if (press[BTN_TIMESET])  mode_next = MODE_SET_TIME;
      end
      default: mode_next = MODE_RUN;
    endcase
  end

  // Dropping repeat_ok on a mode change clears held buttons' timers until a new press.
  assign mode_hold = (mode_next == mode_r);

  always_comb begin
    repeat_ok              = '0;
    repeat_ok[BTN_MINADV]  = mode_hold && (mode_r != MODE_RUN);
    repeat_ok[BTN_HRSADV]  = mode_hold && (mode_r != MODE_RUN);
    repeat_ok[BTN_DAYADV]  = mode_hold && (mode_r == MODE_SET_TIME);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r   <= MODE_RUN;
      Timeset  <= 1'b0;
      Alarmset <= 1'b0;
      Alarmon  <= 1'b0;
    end else begin
      mode_r   <= mode_next;
      Timeset  <= (mode_next == MODE_SET_TIME);
      Alarmset <= (mode_next == MODE_SET_ALARM);
      if (press[BTN_ALARMON]) Alarmon <= ~Alarmon;
    end
  end

  assign mode   = mode_r;
  assign Minadv = strobe[BTN_MINADV];
  assign Hrsadv = strobe[BTN_HRSADV];
  assign Dayadv = strobe[BTN_DAYADV];

  logic unused_btn_bits;
  assign unused_btn_bits = ^{press[BTN_MINADV], press[BTN_HRSADV], press[BTN_DAYADV],
                             strobe[BTN_TIMESET], strobe[BTN_ALARMSET], strobe[BTN_ALARMON]};

endmodule

// File: tb/tb_clock_btn_ctrl.sv
// Bench for clock_btn_ctrl: directed scenarios plus random button activity, every cycle
// compared against an edge-by-edge reference built from the debounce/mode/repeat rules.
module tb_clock_btn_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int RPT  = 3;
  localparam int MAXC = 8192;
  localparam int TS = 0, AS = 1, MN = 2, HR = 3, DY = 4, AO = 5;
`ifdef CLOCK_BTN_AUTORPT_EN
  localparam int EXP_HOLD_STROBES = 6;
`else
  localparam int EXP_HOLD_STROBES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] rawv = '0;
  logic       Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon;
  logic [1:0] mode;

  int n_checks = 0;
  int n_errors = 0;

  clock_btn_ctrl #(
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD),
    .RPT_CYCLES (RPT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .timeset_raw (rawv[0]),
    .alarmset_raw(rawv[1]),
    .minadv_raw  (rawv[2]),
    .hrsadv_raw  (rawv[3]),
    .dayadv_raw  (rawv[4]),
    .alarmon_raw (rawv[5]),
    .Timeset     (Timeset),
    .Alarmset    (Alarmset),
    .Minadv      (Minadv),
    .Hrsadv      (Hrsadv),
    .Dayadv      (Dayadv),
    .Alarmon     (Alarmon),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit raw_hist [0:5][0:MAXC-1];
  int k;
  bit db_a [6];
  bit db_b [6];
  int m_mode;
  bit m_ts, m_as, m_ao;
  bit m_stb [6];
  int start [6];
  int min_cnt, hrs_cnt, day_cnt;

  function automatic int next_mode(int cur, bit t, bit a);
    case (cur)
      0:       return t ? 1 : (a ? 2 : 0);
      1:       return t ? 0 : (a ? 2 : 1);
      default: return a ? 0 : (t ? 1 : 2);
    endcase
  endfunction

  function automatic bit synced(int b, int e);
    return (e >= 2) ? raw_hist[b][e-2] : 1'b0;
  endfunction

  task automatic model_reset();
    k = 0;
    m_mode = 0;
    m_ts = 0; m_as = 0; m_ao = 0;
    for (int b = 0; b < 6; b++) begin
      db_a[b] = 0; db_b[b] = 0; m_stb[b] = 0; start[b] = -1;
    end
  endtask

  task automatic model_step();
    bit pr [6];
    int nm;
    bit ok;
    bit flip;
    if (k >= MAXC) begin
      $display("FAIL model_overflow: edge %0d required below %0d", k, MAXC);
      $fatal(1);
    end
    for (int b = 0; b < 6; b++) pr[b] = db_a[b] && !db_b[b];
    nm = next_mode(m_mode, pr[TS], pr[AS]);
    for (int b = MN; b <= DY; b++) begin
      ok = (nm == m_mode) && ((b == DY) ? (m_mode == 1) : (m_mode != 0));
      m_stb[b] = 0;
      if (!ok || !db_a[b]) start[b] = -1;
      else if (pr[b]) begin
        m_stb[b] = 1;
        start[b] = k;
      end else if (start[b] >= 0) begin : rpt
`ifdef CLOCK_BTN_AUTORPT_EN
        int e;
        e = k - start[b];
        m_stb[b] = (e == HOLD) || (e > HOLD && ((e - HOLD) % RPT) == 0);
`endif
      end
    end
    m_mode = nm;
    m_ts = (nm == 1);
    m_as = (nm == 2);
    if (pr[AO]) m_ao = !m_ao;
    // db flips once the last DB synchronized samples all disagree with it
    for (int b = 0; b < 6; b++) begin
      raw_hist[b][k] = rawv[b];
      flip = 1;
      for (int j = 0; j < DB; j++)
        if ((k - j) < 0 || synced(b, k - j) == db_a[b]) flip = 0;
      db_b[b] = db_a[b];
      if (flip) db_a[b] = !db_a[b];
    end
    k++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("mode", mode, m_mode);
    check("timeset", Timeset, m_ts);
    check("alarmset", Alarmset, m_as);
    check("alarmon", Alarmon, m_ao);
    check("minadv", Minadv, m_stb[MN]);
    check("hrsadv", Hrsadv, m_stb[HR]);
    check("dayadv", Dayadv, m_stb[DY]);
    min_cnt += int'(Minadv);
    hrs_cnt += int'(Hrsadv);
    day_cnt += int'(Dayadv);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic press_btn(input int b, input int hold, input int gap);
    rawv[b] = 1'b1;
    run(hold);
    rawv[b] = 1'b0;
    run(gap);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_ts"}, Timeset, 0);
    check({tag, "_as"}, Alarmset, 0);
    check({tag, "_ao"}, Alarmon, 0);
    check({tag, "_min"}, Minadv, 0);
    check({tag, "_hrs"}, Hrsadv, 0);
    check({tag, "_day"}, Dayadv, 0);
  endtask

  // ---------------- stimulus ----------------
  int dwell [6];

  initial begin
    min_cnt = 0; hrs_cnt = 0; day_cnt = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    run(50);
    check_all_zero("idle");

    press_btn(TS, 10, 10);
    check("ts_mode", mode, 1);
    check("ts_level", Timeset, 1);
    min_cnt = 0;
    press_btn(MN, 3, 20);
    check("min_glitch", min_cnt, 0);
    min_cnt = 0;
    press_btn(MN, 22, 20);
    check("min_hold", min_cnt, EXP_HOLD_STROBES);

    press_btn(TS, 10, 10);
    check("back_run", mode, 0);
    hrs_cnt = 0; day_cnt = 0;
    press_btn(HR, 10, 10);
    press_btn(DY, 10, 10);
    check("run_hrs", hrs_cnt, 0);
    check("run_day", day_cnt, 0);

    press_btn(AS, 10, 10);
    check("as_mode", mode, 2);
    day_cnt = 0;
    press_btn(DY, 6, 12);
    check("alarm_day", day_cnt, 0);
    hrs_cnt = 0;
    press_btn(HR, 5, 12);
    check("alarm_hrs", hrs_cnt, 1);
    press_btn(AS, 10, 10);
    check("as_exit", mode, 0);

    rawv[TS] = 1'b1; rawv[AS] = 1'b1;
    run(10);
    rawv[TS] = 1'b0; rawv[AS] = 1'b0;
    run(10);
    check("tie_mode", mode, 1);
    press_btn(AS, 10, 10);
    check("tie_then_as", mode, 2);
    check("tie_ts", Timeset, 0);
    check("tie_as", Alarmset, 1);

    press_btn(AO, 8, 8);
    check("alarmon_1", Alarmon, 1);
    press_btn(AO, 8, 8);
    check("alarmon_2", Alarmon, 0);

    press_btn(TS, 10, 10);
    check("pre_rst_mode", mode, 1);
    rawv[MN] = 1'b1;
    run(15);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    rawv = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    min_cnt = 0;
    run(30);
    check("post_rst_min", min_cnt, 0);

    for (int b = 0; b < 6; b++) dwell[b] = 0;
    repeat (3000) begin
      for (int b = 0; b < 6; b++) begin
        if (dwell[b] == 0) begin
          rawv[b] = ~rawv[b];
          if (b == TS || b == AS)
            dwell[b] = rawv[b] ? int'($urandom_range(1, 10)) : int'($urandom_range(20, 200));
          else
            dwell[b] = rawv[b] ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
        end else begin
          dwell[b]--;
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
